// File: rtl/div_seq.sv
// div_seq: request/result sequencer around the 64/32 unsigned pipelined divider.
// It turns 32-bit signed or unsigned requests into unsigned divider operands.
// It holds those operands steady for the divider latency, then applies the
// sign fix-up and the divide-by-zero rule, and presents the result on a
// valid/ready port.
//
// Handshake: a request transfers on a clk edge where req_valid & req_ready.
// A result transfers on an edge where res_valid & res_ready. Once raised,
// res_valid and res_* hold until that transfer. req_ready depends only on
// the FSM state.
module div_seq #(
   parameter int LATENCY = 16
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_signed,
   input  logic [31:0] req_x,
   input  logic [31:0] req_d,
   output logic [63:0] div_x,
   output logic [31:0] div_d,
   input  logic [31:0] div_q,
   input  logic [31:0] div_r,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_q,
   output logic [31:0] res_r,
   output logic        res_dz
);

   localparam int CW = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [CW-1:0]   count;
   logic            neg_q;
   logic            neg_r;
   logic            dz_pend;
   logic [31:0]     dz_x;
   logic            accept;
   logic            capture;
   logic            release_res;
   logic [31:0]     ax;
   logic [31:0]     ad;

   assign req_ready = (state == IDLE);

   // Next-state logic and the three transfer strobes.
   always_comb begin
      state_next  = state;
      accept      = 1'b0;
      capture     = 1'b0;
      release_res = 1'b0;
      case (state)
         IDLE: begin
            accept = req_valid;
            if (req_valid) state_next = BUSY;
         end
         BUSY: begin
            capture = (count == '0);
            if (count == '0) state_next = DONE;
         end
         DONE: begin
            release_res = res_ready;
            if (res_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Magnitudes of the operands (a 32-bit negate, so |0x80000000| stays 0x80000000).
   always_comb begin
      ax = (req_signed & req_x[31]) ? (32'd0 - req_x) : req_x;
      ad = (req_signed & req_d[31]) ? (32'd0 - req_d) : req_d;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else       state <= state_next;
   end

   // Operand capture, latency counter and result registers.
   // A zero divisor takes the BUSY state with the counter already at 0.
   // Its result therefore appears one edge after accept, and the divider is untouched.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         count     <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         dz_pend   <= 1'b0;
         dz_x      <= 32'd0;
         div_x     <= 64'd0;
         div_d     <= 32'd0;
         res_valid <= 1'b0;
         res_q     <= 32'd0;
         res_r     <= 32'd0;
         res_dz    <= 1'b0;
      end else begin
         if (accept) begin
            if (req_d == 32'd0) begin
               dz_pend <= 1'b1;
               dz_x    <= req_x;
               count   <= '0;
            end else begin
               dz_pend <= 1'b0;
               neg_q   <= req_signed & (req_x[31] ^ req_d[31]);
               neg_r   <= req_signed & req_x[31];
               div_x   <= {32'd0, ax};
               div_d   <= ad;
               count   <= CW'(LATENCY);
            end
         end else if ((state == BUSY) && (count != '0)) begin
            count <= count - CW'(1);
         end

         if (capture) begin
            res_valid <= 1'b1;
            if (dz_pend) begin
               res_q  <= 32'hFFFF_FFFF;
               res_r  <= dz_x;
               res_dz <= 1'b1;
            end else begin
               res_q  <= neg_q ? (32'd0 - div_q) : div_q;
               res_r  <= neg_r ? (32'd0 - div_r) : div_r;
               res_dz <= 1'b0;
            end
         end else if (release_res) begin
            res_valid <= 1'b0;
         end
      end
   end

endmodule
